// File: rtl/ring_sequencer_if.sv
// ring_sequencer_if: control/status bundle between a host (bench or SoC)
// and the ring_sequencer. The host owns start/abort/target; the sequencer
// owns every status field.
interface ring_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] target;
  logic             busy;
  logic             done;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] osc_count;
  logic             last_value;

  modport master (
    output start, abort, target,
    input  busy, done, fault, fault_code, osc_count, last_value
  );

  modport slave (
    input  start, abort, target,
    output busy, done, fault, fault_code, osc_count, last_value
  );
endinterface

// File: rtl/ring_sequencer.sv
// ring_sequencer: clocked supervisor for a self-timed two-rail NCL ring.
// Holds the ring in init, releases it, watches one ring link through a
// two-flop synchronizer plus a stability check, and counts NULL->DATA
// wavefronts. Stops on target, on a stall (timeout) or on an illegal 11 code.
// Optional feature macro: RING_AUTO_RESTART_EN -- a stall re-enters INIT up
// to three times before the sequencer gives up and reports the timeout.
module ring_sequencer #(
  parameter int INIT_CYCLES = 4,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            init,
  input  logic [1:0]      link,
  output logic            ring_init,
  ring_sequencer_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_FAULT} state_t;

  localparam logic [1:0] C_NULL  = 2'b00;
  localparam logic [1:0] C_ILL   = 2'b11;
  localparam logic [1:0] F_NONE  = 2'b00;
  localparam logic [1:0] F_TMO   = 2'b01;
  localparam logic [1:0] F_ILL   = 2'b10;

  // Synchronizer and stability sample.
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_prev;

  // FSM state and datapath registers.
  state_t           r_state;
  logic [1:0]       r_acc;
  logic [7:0]       r_init_cnt;
  logic [TMO_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_osc_count;
  logic             r_ring_init;
  logic             r_busy;
  logic             r_done;
  logic             r_fault;
  logic [1:0]       r_fault_code;
  logic             r_last_value;
`ifdef RING_AUTO_RESTART_EN
  logic [1:0]       r_retry;
`endif

  logic             w_change;
  logic             w_rise;
  logic             w_illegal;
  logic             w_hit;
  logic             w_tmo_exp;
  logic [CNT_W-1:0] w_cnt_inc;

  // Bring the asynchronous rails into the clk domain and keep one older sample.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true shift chain.
    if (init) begin
      // NOTE: the synchronizer is reset too, so a stale pre-reset code can
      // never be accepted as the first link change of a run.
      r_sync1 <= C_NULL;
      r_sync2 <= C_NULL;
      r_prev  <= C_NULL;
    end else begin
      r_sync1 <= link;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // A code is accepted once it is seen twice in a row; only a difference
  // from the current accepted state is an event.
  assign w_change  = (r_sync2 == r_prev) && (r_sync2 != r_acc);
  assign w_illegal = w_change && (r_sync2 == C_ILL);
  assign w_rise    = w_change && (r_acc == C_NULL) &&
                     ((r_sync2 == 2'b01) || (r_sync2 == 2'b10));
  assign w_cnt_inc = (r_osc_count == '1) ? r_osc_count
                                         : r_osc_count + CNT_W'(1);
  assign w_hit     = (r_target != '0) && (w_cnt_inc == r_target);
  // The stall fires on the edge that completes TIMEOUT quiet cycles.
  assign w_tmo_exp = !w_change && (r_tmo == TMO_W'(TIMEOUT - 1));

  // Supervisor FSM with registered outputs; abort outranks every transition.
  always_ff @(posedge clk) begin
    if (init) begin
      r_state      <= S_IDLE;
      r_acc        <= C_NULL;
      r_init_cnt   <= '0;
      r_tmo        <= '0;
      r_target     <= '0;
      r_osc_count  <= '0;
      r_ring_init  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= F_NONE;
      r_last_value <= 1'b0;
`ifdef RING_AUTO_RESTART_EN
      r_retry      <= 2'd0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_change) r_acc <= r_sync2;

      if (bus.abort) begin
        r_state     <= S_IDLE;
        r_ring_init <= 1'b1;
        r_busy      <= 1'b0;
        r_fault     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_FAULT: begin
            if (bus.start) begin
              r_state      <= S_INIT;
              r_target     <= bus.target;
              r_osc_count  <= '0;
              r_fault_code <= F_NONE;
              r_init_cnt   <= '0;
              r_ring_init  <= 1'b1;
              r_busy       <= 1'b1;
              r_fault      <= 1'b0;
`ifdef RING_AUTO_RESTART_EN
              r_retry      <= 2'd0;
`endif
            end
          end

          S_INIT: begin
            if (r_init_cnt == 8'(INIT_CYCLES - 1)) begin
              r_state     <= S_RUN;
              r_ring_init <= 1'b0;
              r_acc       <= C_NULL;
              r_tmo       <= '0;
            end else begin
              r_init_cnt <= r_init_cnt + 8'd1;
            end
          end

          S_RUN: begin
            if (w_rise) begin
              r_osc_count  <= w_cnt_inc;
              r_last_value <= r_sync2[1];
            end
            if (w_change) r_tmo <= '0;
            else          r_tmo <= r_tmo + TMO_W'(1);

            if (w_illegal) begin
              r_state      <= S_FAULT;
              r_fault_code <= F_ILL;
              r_ring_init  <= 1'b1;
              r_busy       <= 1'b0;
              r_fault      <= 1'b1;
            end else if (w_rise && w_hit) begin
              r_state     <= S_IDLE;
              r_done      <= 1'b1;
              r_ring_init <= 1'b1;
              r_busy      <= 1'b0;
            end else if (w_tmo_exp) begin
`ifdef RING_AUTO_RESTART_EN
              if (r_retry != 2'd3) begin
                r_retry     <= r_retry + 2'd1;
                r_osc_count <= '0;
                r_state     <= S_INIT;
                r_init_cnt  <= '0;
                r_ring_init <= 1'b1;
              end else begin
                r_state      <= S_FAULT;
                r_fault_code <= F_TMO;
                r_ring_init  <= 1'b1;
                r_busy       <= 1'b0;
                r_fault      <= 1'b1;
              end
`else
              r_state      <= S_FAULT;
              r_fault_code <= F_TMO;
              r_ring_init  <= 1'b1;
              r_busy       <= 1'b0;
              r_fault      <= 1'b1;
`endif
            end
          end
        endcase
      end
    end
  end

  assign ring_init      = r_ring_init;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.osc_count  = r_osc_count;
  assign bus.last_value = r_last_value;

endmodule

// File: tb/tb_ring_sequencer.sv
// tb_ring_sequencer: randomized self-checking bench for ring_sequencer.
// A behavioural model built on a link-sample history and phase counters
// predicts every output each cycle; directed sections add literal checks.
module tb_ring_sequencer;
  localparam int INIT_CYCLES = 4;
  localparam int TIMEOUT     = 64;
  localparam int CNT_W       = 16;
`ifdef RING_AUTO_RESTART_EN
  localparam int MAX_RETRY = 3;
`else
  localparam int MAX_RETRY = 0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_FAULT = 3;
  localparam int M_HOLD = 0, M_OSC = 1, M_RAND = 2;

  logic       clk = 1'b0;
  logic       init;
  logic [1:0] link;
  logic       ring_init;
  logic       ring_init4;

  ring_sequencer_if #(.CNT_W(CNT_W)) bus ();
  ring_sequencer_if #(.CNT_W(4))     bus4 ();

  ring_sequencer #(.INIT_CYCLES(INIT_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .init(init), .link(link), .ring_init(ring_init), .bus(bus)
  );

  ring_sequencer #(.INIT_CYCLES(INIT_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut4 (
    .clk(clk), .init(init), .link(link), .ring_init(ring_init4), .bus(bus4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_live = 0;
  int         m_phase, m_init_left, m_since, m_count, m_target, m_code, m_retries;
  bit         m_done, m_last;
  logic [1:0] m_acc;
  logic [1:0] h0, h1, h2;   // link sampled 1, 2 and 3 edges ago

  initial forever begin
    logic [1:0] syn, prv;
    bit chg, rise;
    @(posedge clk);
    if (init) begin
      m_live = 1; m_phase = P_IDLE; m_init_left = 0; m_since = 0; m_count = 0;
      m_target = 0; m_code = 0; m_retries = 0; m_done = 0; m_last = 0;
      m_acc = 2'b00; h0 = 2'b00; h1 = 2'b00; h2 = 2'b00;
    end else begin
      syn  = h1;
      prv  = h2;
      chg  = (syn == prv) && (syn != m_acc);
      rise = chg && (m_acc == 2'b00) && (syn == 2'b01 || syn == 2'b10);
      if (chg) m_acc = syn;
      m_done = 0;
      if (bus.abort) begin
        m_phase = P_IDLE;
      end else if (m_phase == P_IDLE || m_phase == P_FAULT) begin
        if (bus.start) begin
          m_phase = P_INIT; m_target = int'(bus.target); m_count = 0; m_code = 0;
          m_retries = 0; m_init_left = INIT_CYCLES;
        end
      end else if (m_phase == P_INIT) begin
        m_init_left--;
        if (m_init_left == 0) begin
          m_phase = P_RUN; m_acc = 2'b00; m_since = 0;
        end
      end else begin
        if (chg && syn == 2'b11) begin
          m_phase = P_FAULT; m_code = 2;
        end else begin
          if (rise) begin
            m_count = (m_count == CNT_MAX) ? m_count : m_count + 1;
            m_last  = syn[1];
          end
          m_since = chg ? 0 : m_since + 1;
          if (rise && m_target != 0 && m_count == m_target) begin
            m_phase = P_IDLE; m_done = 1;
          end else if (m_since == TIMEOUT) begin
            if (m_retries < MAX_RETRY) begin
              m_retries++; m_count = 0; m_phase = P_INIT; m_init_left = INIT_CYCLES;
            end else begin
              m_phase = P_FAULT; m_code = 1;
            end
          end
        end
      end
    end
    h2 = h1; h1 = h0; h0 = link;
  end

  // ---------------- per-cycle compare ----------------
  int d4_done = 0;
  int main_done = 0;
  initial forever begin
    @(negedge clk);
    if (bus4.done) d4_done++;
    if (bus.done) main_done++;
    if (m_live) begin
      check("ring_init",  ring_init,      m_phase != P_RUN);
      check("busy",       bus.busy,       m_phase == P_INIT || m_phase == P_RUN);
      check("done",       bus.done,       m_done);
      check("fault",      bus.fault,      m_phase == P_FAULT);
      check("fault_code", bus.fault_code, m_code);
      check("osc_count",  bus.osc_count,  m_count);
      check("last_value", bus.last_value, m_last);
    end
  end

  // ---------------- ring / link driver ----------------
  int         mode = M_HOLD;
  logic [1:0] hold_val = 2'b00;
  int         osc_ph = 0;
  int         rand_left = 0;

  task automatic tick();
    @(negedge clk);
    case (mode)
      M_OSC: begin
        osc_ph++;
        if (osc_ph >= 10) begin
          osc_ph = 0;
          link = (link == 2'b00) ? (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01) : 2'b00;
        end
      end
      M_RAND: begin
        if (rand_left == 0) begin
          int r;
          r = int'($urandom_range(0, 15));
          link = (r == 0) ? 2'b11 : ((r % 3 == 0) ? 2'b00 : ((r % 3 == 1) ? 2'b01 : 2'b10));
          rand_left = ($urandom_range(0, 19) == 0) ? 80 : int'($urandom_range(1, 8));
        end else begin
          rand_left--;
        end
      end
      default: link = hold_val;
    endcase
  endtask

  task automatic set_link(input logic [1:0] v);
    mode = M_HOLD; hold_val = v; link = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, cnt, reinit, got, done_before;
    bit prev_ri;
    init = 1'b1; link = 2'b00;
    bus.start = 0;  bus.abort = 0;  bus.target = '0;
    bus4.start = 0; bus4.abort = 0; bus4.target = '0;
    repeat (3) @(negedge clk);
    init = 1'b0;
    tick();
    check("rst_ring_init", ring_init, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.osc_count, 0);

    // Main DUT idles while the ring oscillates; CNT_W=4 DUT free-runs into saturation.
    bus4.target = '0; bus4.start = 1; tick(); bus4.start = 0;
    osc_ph = 0; mode = M_OSC;
    repeat (460) tick();
    check("idle_toggle_count", bus.osc_count, 0);
    check("sat_count", bus4.osc_count, 15);
    check("sat_busy", bus4.busy, 1);
    bus4.abort = 1; tick(); bus4.abort = 0; tick();
    check("abort_busy", bus4.busy, 0);
    check("abort_ring_init", ring_init4, 1);
    check("abort_keep_count", bus4.osc_count, 15);
    check("abort_no_done", d4_done, 0);

    // Normal run to target 5.
    set_link(2'b00); repeat (12) tick();
    bus.target = 16'd5; bus.start = 1; osc_ph = 0; mode = M_OSC;
    tick(); bus.start = 0;
    cyc = 1;
    while (ring_init && cyc < 50) begin tick(); cyc++; end
    check("init_len", cyc, INIT_CYCLES + 1);
    got = 0;
    for (int i = 0; i < 300 && got == 0; i++) begin
      tick();
      if (bus.done) got = 1;
    end
    check("done_seen", got, 1);
    check("done_count", bus.osc_count, 5);
    check("done_ring_init", ring_init, 1);
    check("model_count", m_count, 5);
    tick();
    check("done_once", bus.done, 0);
    check("idle_after_done", bus.busy, 0);

    // Stall: free-run, then freeze the ring at DATA.
    bus.target = '0; bus.start = 1; tick(); bus.start = 0;
    repeat (50) tick();
    set_link(2'b00); repeat (12) tick();
    set_link(2'b01);
    cnt = 0; reinit = 0; prev_ri = ring_init;
    for (int i = 0; i < 1500 && !bus.fault; i++) begin
      tick(); cnt++;
      if (ring_init && !prev_ri && bus.busy) reinit++;
      prev_ri = ring_init;
    end
    check("stall_fault", bus.fault, 1);
    check("stall_code", bus.fault_code, 1);
    check("stall_retries", reinit, MAX_RETRY);
    check("stall_latency", cnt, 4 + TIMEOUT + MAX_RETRY * (INIT_CYCLES + 1 + TIMEOUT));
    check("model_code_tmo", m_code, 1);

    // Illegal 11 held three cycles in RUN (started from FAULT).
    set_link(2'b00);
    bus.start = 1; tick(); bus.start = 0;
    for (int i = 0; i < 20 && ring_init; i++) tick();
    check("ill_in_run", ring_init, 0);
    repeat (5) tick();
    set_link(2'b11); repeat (3) tick(); set_link(2'b00);
    for (int i = 0; i < 10 && !bus.fault; i++) tick();
    check("ill_fault", bus.fault, 1);
    check("ill_code", bus.fault_code, 2);
    check("ill_busy", bus.busy, 0);

    // Glitch on NULL: no count, timeout still measured from RUN entry.
    bus.start = 1; tick(); bus.start = 0;
    for (int i = 0; i < 20 && ring_init; i++) tick();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); cnt++; end
    set_link(2'b01); tick(); cnt++; set_link(2'b00);
    while (!ring_init && cnt < 200) begin tick(); cnt++; end
    check("glitch_no_reload", cnt, TIMEOUT);
    check("glitch_count", bus.osc_count, 0);
    done_before = main_done;
    bus.abort = 1; tick(); bus.abort = 0; tick();
    check("abort_idle", bus.busy, 0);
    check("abort_fault_clr", bus.fault, 0);
    check("abort_done_none", main_done, done_before);

    // Randomized runs: random link, targets, held start and sporadic aborts.
    for (int run = 0; run < 8; run++) begin
      bit hold_start;
      hold_start = ($urandom_range(0, 1) == 1);
      bus.target = CNT_W'($urandom_range(0, 4));
      mode = M_RAND; rand_left = 0;
      bus.start = 1; tick(); bus.start = hold_start;
      for (int i = 0; i < 400; i++) begin
        bus.abort = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 49) == 0) bus.target = CNT_W'($urandom_range(0, 4));
        tick();
      end
      bus.start = 0;
      bus.abort = 1; tick(); bus.abort = 0; tick();
      check("rand_idle", bus.busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_sequencer.md
# ring_sequencer

Clocked supervisor for a self-timed two-rail NCL pipeline ring (the four-stage oscillating ring). On command it holds the ring in `init`, releases it, samples one ring link through a synchronizer, and counts DATA wavefronts. It stops when the count reaches a target, and flags a fault on stall or illegal rail encoding. It is the only clocked element touching the ring and is the bench/SoC-facing control point for ring experiments.

## Interface
Parameters:
- `INIT_CYCLES`, default 4: minimum clk cycles `ring_init` is held after `start`; legal range 1–255.
- `TIMEOUT`, default 64: clk cycles without an accepted link change before stall; legal range 2–65535.
- `CNT_W`, default 16: width of `target` and `osc_count`.

Ports:
- `clk` in 1: sole clock.
- `init` in 1: reset, synchronous, active-high.
- `start` in 1: level-sampled; begins a run when in IDLE or FAULT.
- `abort` in 1: returns to IDLE from any non-IDLE state.
- `target` in CNT_W: wavefront count to reach; sampled on accepted `start`; 0 means free-run.
- `link` in 2: asynchronous two-rail link sampled from the ring (e.g. stage-A rails).
- `ring_init` out 1: drives the ring's `init`; high in every state except RUN.
- `busy` out 1: high in INIT and RUN.
- `done` out 1: one-cycle pulse on reaching target.
- `fault` out 1: high in FAULT.
- `fault_code` out 2: 00 none, 01 timeout, 10 illegal rail code 11.
- `osc_count` out CNT_W: accepted NULL→DATA transitions this run; saturates at all-ones.
- `last_value` out 1: rail[1] of the most recent accepted DATA.

## Operation
- Synchronizer: 2 flops on each `link` rail. A code is "accepted" when the synchronized code equals the previous sample (stable for 2 consecutive cycles). Accepted state updates only when the code differs from the current accepted state.
- Codes: 00 NULL; 01/10 DATA (value = rail[1]); 11 illegal.
- States:
  - IDLE: `start` → INIT. Captures `target`, clears `osc_count`, `fault_code`, and the retry counter.
  - INIT: counts `INIT_CYCLES` cycles, then → RUN. Accepted state is forced to NULL on exit.
  - RUN: `ring_init`=0.
    - Accepted NULL→DATA increments `osc_count` and updates `last_value`.
    - Any accepted change reloads the timeout counter.
    - `osc_count` reaching nonzero `target` → IDLE with a `done` pulse.
    - Timeout expiry → FAULT with code 01 (see Configuration).
    - Accepted 11 → FAULT with code 10, always regardless of retries.
  - FAULT: outputs held; `start` → INIT with the same clears as IDLE.
- `abort` has priority over every transition except reset. It sends the FSM to IDLE with no `done` pulse and retains `osc_count`.
- Priority within a RUN cycle: abort > illegal > target reached > timeout.
- `start` held high through IDLE re-arms immediately the cycle after `done`. This is intended free-cycling.

## Timing
- Reset values: state IDLE, `ring_init`=1, `busy`=0, `done`=0, `fault`=0, `fault_code`=00, `osc_count`=0, `last_value`=0.
- `start` sampled at cycle N → INIT at N+1, `ring_init` high for exactly `INIT_CYCLES` cycles, low from N+1+`INIT_CYCLES`.
- Link edge to `osc_count` update: 3–4 clk (2 sync stages + 1 stability cycle + register).
- `done` is asserted in the same cycle `ring_init` returns to 1.
- The timeout counter is `$clog2(TIMEOUT+1)` bits. Stall is declared on the cycle the counter has run `TIMEOUT` cycles since the last reload; it reloads on RUN entry.
- Reset mid-run: the next cycle shows reset values, so the ring is held in `init`.

## Configuration
- `RING_AUTO_RESTART_EN` defined: on timeout in RUN, if the 2-bit retry counter < 3, increment it, clear `osc_count`, and go to INIT instead of FAULT. On the 4th timeout, go to FAULT with code 01. `busy` stays high across retries.
- `RING_AUTO_RESTART_EN` undefined: the first timeout goes straight to FAULT with code 01, and the retry counter is not implemented.

## Test plan
- Reset then idle: after `init` pulse, `ring_init`=1, `busy`=0, `osc_count`=0. `link` toggling in IDLE leaves `osc_count` unchanged.
- Normal run: `INIT_CYCLES`=4, `target`=5. Bench ring model alternates NULL/DATA every 10 clk → `ring_init` low 4 cycles after start, `done` pulse after 5th DATA, `osc_count`=5, FSM back to IDLE.
- Stall: ring model freezes at DATA, `TIMEOUT`=64 → without macro, `fault`=1 and `fault_code`=01 exactly 64 cycles after the last accepted change. With macro, 3 INIT re-entries, then FAULT.
- Illegal code: drive `link`=11 stable for 3 cycles in RUN → FAULT with `fault_code`=10, no retry even with macro.
- Glitch rejection: 1-cycle pulse on `link[0]` while NULL → no count, timeout not reloaded.
- Abort/saturation: `target`=0 with `osc_count` preset near all-ones (`CNT_W`=4, 20 wavefronts) → `osc_count` holds 15. `abort` → IDLE, no `done`, count retained.
